alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Sequences the alarm sound path: arms on bud_on, detects entry into the alarm minute,
//  rings with a beep pattern, and handles stop, snooze (re-arm at now+SNOOZE_MIN) and ring timeout.
//  Runs on the 1 Hz second tick. Drives aud_en to the audio driver and alarm status to the display.
// PARAMETERS
//  RING_SEC    60  ring cycles before auto-stop (1..255)
//  SNOOZE_MIN  5   snooze offset in minutes (1..59)
//  MAX_SNOOZE  3   snoozes allowed per alarm event (1..7)
//  BEEP_ON     1   cycles aud_en high per beep period
//  BEEP_OFF    1   cycles aud_en low per beep period
// PORTS
//  clk_sec        in   1  1 Hz system clock, rising edge
//  rst            in   1  asynchronous reset, active-high
//  bud_on         in   1  alarm enable level; 0 forces IDLE
//  snooze_btn     in   1  one-cycle pulse, debounced, synchronous to clk_sec
//  stop_btn       in   1  one-cycle pulse, debounced, synchronous to clk_sec
//  hourdec_bud, hourone_bud, mindec_bud, minone_bud  in  4 each  alarm time, BCD, valid 00:00..23:59
//  hourdec_now, hourone_now, mindec_now, minone_now  in  4 each  current time, BCD
//  aud_en         out  1  sound enable, registered
//  bud_state      out  1  1 = state RINGING
//  snooze_active  out  1  1 = state SNOOZE
//  snooze_left    out  3  remaining snoozes = MAX_SNOOZE - snooze_cnt
// BEHAVIOUR
//  Reset: state=IDLE, aud_en=0, bud_state=0, snooze_active=0, snooze_cnt=0, ring_cnt=0,
//   beep phase=0, snooze target=00:00, match_bud_q=1, match_snz_q=1.
//   Reset high mid-ring stops sound immediately (async).
//  Match detection:
//   - hit_bud = (now==bud) && !match_bud_q
//   - hit_snz = (now==target) && !match_snz_q
//   - The _q registers update every cycle.
//   - Only entry into a matching minute triggers. Staying in the minute, or leaving reset
//     while already inside it, never triggers.
//   - Changing the bud time to the current minute triggers.
//  States: IDLE, ARMED, RINGING, SNOOZE.
//   Priority per cycle: !bud_on > stop_btn > snooze_btn > timeout/hit.
//  Transitions:
//   - any state, !bud_on -> IDLE next edge; snooze_cnt cleared.
//   - IDLE,    bud_on -> ARMED.
//   - ARMED,   hit_bud -> RINGING; ring_cnt=0; phase=0; snooze_cnt=0.
//   - RINGING, stop_btn -> ARMED.
//   - RINGING, snooze_btn && snooze_cnt<MAX_SNOOZE -> SNOOZE; target=now+SNOOZE_MIN; snooze_cnt++.
//     snooze_btn at the limit is ignored (keeps ringing).
//   - RINGING, ring_cnt==RING_SEC-1 -> ARMED (timeout).
//   - SNOOZE,  stop_btn -> ARMED.
//   - SNOOZE,  hit_snz -> RINGING; ring_cnt=0; phase=0. hit_bud is ignored in SNOOZE.
//   - ARMED ignores snooze_btn and stop_btn.
//  Outputs:
//   - Registered; 1-cycle latency from the triggering edge. Edge N sees the hit; after edge N
//     bud_state=1 and aud_en=1.
//   - aud_en=1 iff next state is RINGING && next phase<BEEP_ON.
//   - phase counts 0..BEEP_ON+BEEP_OFF-1 and wraps.
//  Snooze target arithmetic:
//   - minutes: m = 10*mindec + minone + SNOOZE_MIN. If m>=60: m-=60, carry into hours.
//   - hours wrap 23 -> 00.
//   - Result stored as BCD.
//  Width: ring_cnt = $clog2(RING_SEC) bits; snooze_cnt = 3 bits.
// STRUCTURE
//  alarm_pkg:
//   - typedef enum logic[1:0] alarm_state_t {IDLE, ARMED, RINGING, SNOOZE}
//   - typedef struct packed bcd_time_t {hd, ho, md, mo}
//  Sub-module bcd_time_add (combinational): bcd_time_t + minutes -> bcd_time_t, with 24 h wrap.
//  Top: FSM, counters, match registers, target register.
// TESTING
//  1. bud_on=1, alarm 07:30, now 07:29->07:30: next edge bud_state=1; aud_en=1,0,1,0...
//  2. Ringing at 07:30, snooze pulse: snooze_active=1, aud_en=0, snooze_left=2;
//     now 07:35 -> RINGING next edge.
//  3. Alarm 23:58, snooze at 23:58 -> target 00:03; now 00:03 rings; now 00:02 does not.
//  4. No buttons: after 60 ring cycles -> ARMED, aud_en=0; now still 07:30 -> no retrigger.
//  5. Three snoozes used; 4th snooze pulse ignored (bud_state stays 1); stop -> ARMED.
//  6. rst mid-ring -> aud_en=0 at once. Release with now==alarm and bud_on=1 -> ARMED,
//     no ring until the next entry into 07:30.

Source files
------------

// File: rtl/alarm_pkg.sv
`timescale 1ns/1ps
// alarm_pkg
// Shared types for the alarm sound path.
//   alarm_state_t : sequencer states (IDLE, ARMED, RINGING, SNOOZE)
//   bcd_time_t    : HH:MM time as four BCD digits (hour tens/ones, minute tens/ones)
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZE
  } alarm_state_t;

  typedef struct packed {
    logic [3:0] hd;
    logic [3:0] ho;
    logic [3:0] md;
    logic [3:0] mo;
  } bcd_time_t;

endpackage

// File: rtl/bcd_time_add.sv
`timescale 1ns/1ps
// bcd_time_add
// Combinational BCD clock adder: adds a minute offset (0..59) to a valid
// 00:00..23:59 BCD time, carrying into the hour and wrapping 23 -> 00.
// Ports:
//   base    in  bcd_time_t  time to offset
//   add_min in  6           minutes to add
//   sum     out bcd_time_t  resulting time, BCD
module bcd_time_add
  import alarm_pkg::*;
(
  input  bcd_time_t  base,
  input  logic [5:0] add_min,
  output bcd_time_t  sum
);

  logic [6:0] min_bin;
  logic [6:0] min_wrap;
  logic [5:0] hour_bin;
  logic [4:0] hour_wrap;
  logic       carry;

  // Work in binary minutes/hours, then split back into BCD digits.
  // Max minute sum is 59+59, so a single subtract of 60 is enough.
  always_comb begin
    min_bin   = 7'(base.md) * 7'd10 + 7'(base.mo) + 7'(add_min);
    carry     = (min_bin >= 7'd60);
    min_wrap  = carry ? (min_bin - 7'd60) : min_bin;
    hour_bin  = 6'(base.hd) * 6'd10 + 6'(base.ho) + 6'(carry);
    hour_wrap = (hour_bin >= 6'd24) ? 5'(hour_bin - 6'd24) : 5'(hour_bin);
    sum.md    = 4'(min_wrap / 7'd10);
    sum.mo    = 4'(min_wrap % 7'd10);
    sum.hd    = 4'(hour_wrap / 5'd10);
    sum.ho    = 4'(hour_wrap % 5'd10);
  end

endmodule

// File: rtl/alarm_sequencer.sv
`timescale 1ns/1ps
// alarm_sequencer
// Alarm sound-path sequencer on the 1 Hz tick: arms while bud_on is high,
// rings on entry into the alarm minute with an on/off beep pattern, and
// handles stop, snooze (re-ring at now+SNOOZE_MIN, limited count) and
// ring timeout.
// Ports:
//   clk_sec        in  1  1 Hz clock, rising edge
//   rst            in  1  asynchronous reset, active-high
//   bud_on         in  1  alarm enable level; low forces IDLE
//   snooze_btn     in  1  one-cycle snooze pulse
//   stop_btn       in  1  one-cycle stop pulse
//   *_bud          in  4  alarm time digits, BCD
//   *_now          in  4  current time digits, BCD
//   aud_en         out 1  registered sound enable
//   bud_state      out 1  state is RINGING
//   snooze_active  out 1  state is SNOOZE
//   snooze_left    out 3  remaining snoozes for this alarm event
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned BEEP_ON    = 1,
  parameter int unsigned BEEP_OFF   = 1
) (
  input  logic       clk_sec,
  input  logic       rst,
  input  logic       bud_on,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  input  logic [3:0] hourdec_bud,
  input  logic [3:0] hourone_bud,
  input  logic [3:0] mindec_bud,
  input  logic [3:0] minone_bud,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  output logic       aud_en,
  output logic       bud_state,
  output logic       snooze_active,
  output logic [2:0] snooze_left
);

  localparam int unsigned RING_W   = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam int unsigned BEEP_LEN = BEEP_ON + BEEP_OFF;
  localparam int unsigned PHASE_W  = (BEEP_LEN > 1) ? $clog2(BEEP_LEN) : 1;
  localparam logic [RING_W-1:0]  RING_LAST    = RING_W'(RING_SEC - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(BEEP_LEN - 1);
  localparam logic [2:0]         SNOOZE_LIMIT = 3'(MAX_SNOOZE);

  alarm_state_t       state, state_next;
  logic [RING_W-1:0]  ring_cnt, ring_next;
  logic [PHASE_W-1:0] phase, phase_next;
  logic [2:0]         snooze_cnt, snooze_cnt_next;
  bcd_time_t          now_t, bud_t, target_q, target_next, target_sum;
  logic               match_bud, match_snz, match_bud_q, match_snz_q;
  logic               hit_bud, hit_snz, snooze_ok;
  logic               aud_en_next, bud_state_next, snooze_active_next;

  assign now_t = {hourdec_now, hourone_now, mindec_now, minone_now};
  assign bud_t = {hourdec_bud, hourone_bud, mindec_bud, minone_bud};

  bcd_time_add u_snooze_add (
    .base    (now_t),
    .add_min (6'(SNOOZE_MIN)),
    .sum     (target_sum)
  );

  // Only the first cycle of a matching minute counts as a hit; the match
  // flags reset to 1 so coming out of reset inside the minute never rings.
  assign match_bud = (now_t == bud_t);
  assign match_snz = (now_t == target_q);
  assign hit_bud   = match_bud && !match_bud_q;
  assign hit_snz   = match_snz && !match_snz_q;
  assign snooze_ok = snooze_btn && (snooze_cnt < SNOOZE_LIMIT);

  assign snooze_left = SNOOZE_LIMIT - snooze_cnt;

  // State register plus all datapath registers; reset also silences audio
  // immediately since aud_en is cleared asynchronously.
  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ring_cnt      <= '0;
      phase         <= '0;
      snooze_cnt    <= '0;
      target_q      <= '0;
      match_bud_q   <= 1'b1;
      match_snz_q   <= 1'b1;
      aud_en        <= 1'b0;
      bud_state     <= 1'b0;
      snooze_active <= 1'b0;
    end else begin
      state         <= state_next;
      ring_cnt      <= ring_next;
      phase         <= phase_next;
      snooze_cnt    <= snooze_cnt_next;
      target_q      <= target_next;
      match_bud_q   <= match_bud;
      match_snz_q   <= match_snz;
      aud_en        <= aud_en_next;
      bud_state     <= bud_state_next;
      snooze_active <= snooze_active_next;
    end
  end

  // Next-state and counter logic. Priority: !bud_on, then stop, then
  // snooze, then timeout or time hit.
  always_comb begin
    state_next      = state;
    ring_next       = '0;
    phase_next      = '0;
    snooze_cnt_next = snooze_cnt;
    target_next     = target_q;

    if (!bud_on) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARMED;
        ARMED:   if (hit_bud) state_next = RINGING;
        RINGING: begin
          if (stop_btn)                  state_next = ARMED;
          else if (snooze_ok)            state_next = SNOOZE;
          else if (ring_cnt == RING_LAST) state_next = ARMED;
        end
        SNOOZE: begin
          if (stop_btn)     state_next = ARMED;
          else if (hit_snz) state_next = RINGING;
        end
        default: state_next = IDLE;
      endcase
    end

    // Counters continue only while ringing persists; any fresh entry
    // into RINGING starts both from zero.
    if (state == RINGING && state_next == RINGING) begin
      ring_next  = ring_cnt + RING_W'(1);
      phase_next = (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
    end

    if (!bud_on) begin
      snooze_cnt_next = '0;
    end else if (state == ARMED && state_next == RINGING) begin
      snooze_cnt_next = '0;
    end else if (state == RINGING && state_next == SNOOZE) begin
      snooze_cnt_next = snooze_cnt + 3'd1;
      target_next     = target_sum;
    end
  end

  // Registered outputs are derived from the next state so they change on
  // the same edge that detects the event.
  always_comb begin
    bud_state_next     = (state_next == RINGING);
    snooze_active_next = (state_next == SNOOZE);
    aud_en_next        = (state_next == RINGING) && (32'(phase_next) < BEEP_ON);
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
`timescale 1ns/1ps
// tb_alarm_sequencer
// Self-checking bench for alarm_sequencer: a directed vector table for the
// basic arm/ring/snooze/stop flow, plus hand-written sequences for the
// midnight wrap, ring timeout, snooze limit and asynchronous reset.
module tb_alarm_sequencer;

  logic        clk_sec = 1'b0;
  logic        rst = 1'b0;
  logic        bud_on = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic [15:0] now_time = 16'h0729;
  logic [15:0] bud_time = 16'h0730;
  logic        aud_en, bud_state, snooze_active;
  logic [2:0]  snooze_left;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        on;
    logic        snz;
    logic        stp;
    logic [15:0] now;
    logic [15:0] bud;
    logic        ea;
    logic        eb;
    logic        es;
    logic [2:0]  el;
  } vec_t;

  vec_t vecs[18];

  always #5 clk_sec = ~clk_sec;

  alarm_sequencer #(
    .RING_SEC   (60),
    .SNOOZE_MIN (5),
    .MAX_SNOOZE (3),
    .BEEP_ON    (1),
    .BEEP_OFF   (1)
  ) dut (
    .clk_sec       (clk_sec),
    .rst           (rst),
    .bud_on        (bud_on),
    .snooze_btn    (snooze_btn),
    .stop_btn      (stop_btn),
    .hourdec_bud   (bud_time[15:12]),
    .hourone_bud   (bud_time[11:8]),
    .mindec_bud    (bud_time[7:4]),
    .minone_bud    (bud_time[3:0]),
    .hourdec_now   (now_time[15:12]),
    .hourone_now   (now_time[11:8]),
    .mindec_now    (now_time[7:4]),
    .minone_now    (now_time[3:0]),
    .aud_en        (aud_en),
    .bud_state     (bud_state),
    .snooze_active (snooze_active),
    .snooze_left   (snooze_left)
  );

  // Drive inputs, take one clock edge, release the button pulses.
  task automatic applyStimulus(input logic on, input logic snz, input logic stp,
                               input logic [15:0] now, input logic [15:0] bud);
    bud_on     = on;
    snooze_btn = snz;
    stop_btn   = stp;
    now_time   = now;
    bud_time   = bud;
    @(posedge clk_sec);
    #1;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic ea, input logic eb,
                             input logic es, input logic [2:0] el);
    checks++;
    if ({aud_en, bud_state, snooze_active, snooze_left} !== {ea, eb, es, el}) begin
      errors++;
      $display("[TB] FAIL %s: aud_en/bud_state/snooze_active/snooze_left got %b/%b/%b/%0d expected %b/%b/%b/%0d",
               name, aud_en, bud_state, snooze_active, snooze_left, ea, eb, es, el);
    end
  endtask

  // Reset held across one edge with the alarm disabled.
  task automatic doReset(input logic [15:0] now, input logic [15:0] bud);
    bud_on     = 1'b0;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    now_time   = now;
    bud_time   = bud;
    rst        = 1'b1;
    @(posedge clk_sec);
    #1;
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // on snz stp now bud : aud bud_state snooze_active snooze_left
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0729, 16'h0730, 1'b0, 1'b0, 1'b0, 3'd3};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0729, 16'h0730, 1'b0, 1'b0, 1'b0, 3'd3};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730, 1'b1, 1'b1, 1'b0, 3'd3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730, 1'b0, 1'b1, 1'b0, 3'd3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730, 1'b1, 1'b1, 1'b0, 3'd3};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730, 1'b0, 1'b1, 1'b0, 3'd3};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0730, 16'h0730, 1'b0, 1'b0, 1'b1, 3'd2};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0731, 16'h0730, 1'b0, 1'b0, 1'b1, 3'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0734, 16'h0730, 1'b0, 1'b0, 1'b1, 3'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0735, 16'h0730, 1'b1, 1'b1, 1'b0, 3'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0735, 16'h0730, 1'b0, 1'b1, 1'b0, 3'd2};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0735, 16'h0730, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0736, 16'h0730, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0736, 16'h0730, 1'b0, 1'b0, 1'b0, 3'd3};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 16'h0736, 16'h0730, 1'b0, 1'b0, 1'b0, 3'd3};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 16'h0736, 16'h0730, 1'b0, 1'b0, 1'b0, 3'd3};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 16'h0736, 16'h0736, 1'b1, 1'b1, 1'b0, 3'd3};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0736, 16'h0736, 1'b0, 1'b0, 1'b0, 3'd3};

    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #1 checkOutput("reset", 1'b0, 1'b0, 1'b0, 3'd3);
    @(posedge clk_sec);
    #1 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].on, vecs[i].snz, vecs[i].stp, vecs[i].now, vecs[i].bud);
      checkOutput($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].es, vecs[i].el);
    end

    // Snooze across midnight: 23:58 + 5 min -> 00:03.
    doReset(16'h2357, 16'h2358);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h2357, 16'h2358);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h2357, 16'h2358);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h2358, 16'h2358);
    checkOutput("wrap_ring", 1'b1, 1'b1, 1'b0, 3'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h2358, 16'h2358);
    checkOutput("wrap_snooze", 1'b0, 1'b0, 1'b1, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h2359, 16'h2358);
    checkOutput("wrap_2359", 1'b0, 1'b0, 1'b1, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h2358);
    checkOutput("wrap_0000", 1'b0, 1'b0, 1'b1, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0002, 16'h2358);
    checkOutput("wrap_0002", 1'b0, 1'b0, 1'b1, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0003, 16'h2358);
    checkOutput("wrap_0003", 1'b1, 1'b1, 1'b0, 3'd2);

    // Ring timeout after 60 ring cycles, no retrigger inside the minute.
    doReset(16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
    checkOutput("tmo_ring0", 1'b1, 1'b1, 1'b0, 3'd3);
    for (int k = 1; k < 60; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
      checkOutput($sformatf("tmo_ring%0d", k), logic'(k % 2 == 0), 1'b1, 1'b0, 3'd3);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
    checkOutput("tmo_armed", 1'b0, 1'b0, 1'b0, 3'd3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
      checkOutput($sformatf("tmo_noretrig%0d", k), 1'b0, 1'b0, 1'b0, 3'd3);
    end

    // Snooze limit: three snoozes, fourth ignored, stop beats snooze.
    doReset(16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
    checkOutput("lim_ring", 1'b1, 1'b1, 1'b0, 3'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0730, 16'h0730);
    checkOutput("lim_snz1", 1'b0, 1'b0, 1'b1, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0731, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0735, 16'h0730);
    checkOutput("lim_ring2", 1'b1, 1'b1, 1'b0, 3'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0735, 16'h0730);
    checkOutput("lim_snz2", 1'b0, 1'b0, 1'b1, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0736, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0740, 16'h0730);
    checkOutput("lim_ring3", 1'b1, 1'b1, 1'b0, 3'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0740, 16'h0730);
    checkOutput("lim_snz3", 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0741, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0745, 16'h0730);
    checkOutput("lim_ring4", 1'b1, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0745, 16'h0730);
    checkOutput("lim_snz4_ignored", 1'b0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0745, 16'h0730);
    checkOutput("lim_snz5_ignored", 1'b1, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0745, 16'h0730);
    checkOutput("lim_stop", 1'b0, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset mid-ring, release inside the alarm minute.
    doReset(16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0729, 16'h0730);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
    checkOutput("arst_ring", 1'b1, 1'b1, 1'b0, 3'd3);
    #2 rst = 1'b1;
    #1 checkOutput("arst_immediate", 1'b0, 1'b0, 1'b0, 3'd3);
    @(posedge clk_sec);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
    checkOutput("arst_armed", 1'b0, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
    checkOutput("arst_no_ring", 1'b0, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0731, 16'h0730);
    checkOutput("arst_0731", 1'b0, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0730, 16'h0730);
    checkOutput("arst_reentry", 1'b1, 1'b1, 1'b0, 3'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
